flash_cmd_sequencer: RTL and testbench

- Control stage directly upstream of the Address block. Generates the one-hot address-select strobes (SelAddr/Sel5555/SelAAAA/SelHOLD/SelXXXX) and the IncrAddr pulse.
- Drives the parallel flash bus (CE_n/WE_n/OE_n/DQ) for two operations, both started by the I2C slave controller:
  - byte-program: software-data-protect unlock, then program, then DQ7 data polling
  - byte-read
- Address bytes are loaded into the Address block by the I2C controller before Start. This block sequences only the bus cycles.

---
 rtl/flash_seq_pkg.sv | 44 ++++
 rtl/flash_cmd_sequencer_if.sv | 35 +++
 rtl/flash_cycle_timer.sv | 26 ++
 rtl/flash_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_flash_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the flash command sequencer: FSM states, JEDEC
// software-data-protect command bytes and the one-hot Address-block select codes.
package flash_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmdSetup,
        StCmdWe,
        StCmdRec,
        StPollOe,
        StPollChk,
        StRdOe,
        StFinish
    } state_e;

    localparam logic [7:0] CMD_UNLOCK1 = 8'hAA;
    localparam logic [7:0] CMD_UNLOCK2 = 8'h55;
    localparam logic [7:0] CMD_PROGRAM = 8'hA0;

    // Bit order matches {SelXXXX, SelHOLD, SelAAAA, Sel5555, SelAddr}.
    localparam logic [4:0] SEL_ADDR = 5'b00001;
    localparam logic [4:0] SEL_5555 = 5'b00010;
    localparam logic [4:0] SEL_AAAA = 5'b00100;
    localparam logic [4:0] SEL_HOLD = 5'b01000;
    localparam logic [4:0] SEL_XXXX = 5'b10000;

    typedef struct packed {
        logic [4:0] sel;
        logic [7:0] data;
    } bus_cmd_t;

    // Address select and data byte for write bus cycle k of the program sequence.
    function automatic bus_cmd_t cmd_step(input logic [1:0] k, input logic [7:0] wr_data);
        bus_cmd_t c;
        unique case (k)
            2'd0: begin c.sel = SEL_5555; c.data = CMD_UNLOCK1; end
            2'd1: begin c.sel = SEL_AAAA; c.data = CMD_UNLOCK2; end
            2'd2: begin c.sel = SEL_5555; c.data = CMD_PROGRAM; end
            2'd3: begin c.sel = SEL_ADDR; c.data = wr_data;     end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// Request/status handshake with the I2C controller, Address-block selects and the
// parallel flash bus, bundled for the command sequencer.
interface flash_cmd_sequencer_if;
    logic       StartWrite;
    logic       StartRead;
    logic [7:0] WrData;
    logic [7:0] FlashDQ_in;
    logic       SelAddr;
    logic       Sel5555;
    logic       SelAAAA;
    logic       SelHOLD;
    logic       SelXXXX;
    logic       IncrAddr;
    logic [7:0] FlashDQ_out;
    logic       FlashDQ_oe;
    logic       CE_n;
    logic       WE_n;
    logic       OE_n;
    logic [7:0] RdData;
    logic       Busy;
    logic       Done;
    logic       Error;

    modport master (
        output StartWrite, StartRead, WrData, FlashDQ_in,
        input  SelAddr, Sel5555, SelAAAA, SelHOLD, SelXXXX, IncrAddr,
        input  FlashDQ_out, FlashDQ_oe, CE_n, WE_n, OE_n, RdData, Busy, Done, Error
    );

    modport slave (
        input  StartWrite, StartRead, WrData, FlashDQ_in,
        output SelAddr, Sel5555, SelAAAA, SelHOLD, SelXXXX, IncrAddr,
        output FlashDQ_out, FlashDQ_oe, CE_n, WE_n, OE_n, RdData, Busy, Done, Error
    );
endinterface

// File: rtl/flash_cycle_timer.sv
// Loadable 4-bit down-counter with a zero flag; times the WE_n and OE_n low phases.
module flash_cycle_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       zero_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 4'd0);
endmodule

// File: rtl/flash_cmd_sequencer.sv
// Sequences flash bus cycles for byte-program (SDP unlock, program, DQ7 polling) and
// byte-read, and drives the one-hot select strobes of the Address block.
module flash_cmd_sequencer
    import flash_seq_pkg::*;
#(
    parameter int unsigned WE_PULSE = 2,
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned POLL_MAX = 1024
) (
    input logic                  SCL,
    input logic                  Reset,
    flash_cmd_sequencer_if.slave bus
);
    // The timer counts down to zero, so a wait of N cycles loads N-1.
    localparam logic [3:0]  WePulseM1 = 4'(WE_PULSE - 1);
    localparam logic [3:0]  RdWaitM1  = 4'(RD_WAIT - 1);
    localparam logic [10:0] PollMax   = 11'(POLL_MAX);

    state_e      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        rd_op_q, rd_op_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [10:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        error_q, error_d;
    logic        timer_load, timer_zero;
    logic [3:0]  timer_val;
    bus_cmd_t    cmd;
    logic [4:0]  sel;

    flash_cycle_timer u_timer (
        .clk_i      (SCL),
        .rst_i      (Reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge SCL) begin
        if (Reset) begin
            state_q    <= StIdle;
            k_q        <= 2'd0;
            rd_op_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            poll_cnt_q <= 11'd0;
            rd_data_q  <= 8'h00;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_op_q    <= rd_op_d;
            wr_data_q  <= wr_data_d;
            poll_cnt_q <= poll_cnt_d;
            rd_data_q  <= rd_data_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_op_d    = rd_op_q;
        wr_data_d  = wr_data_q;
        poll_cnt_d = poll_cnt_q;
        rd_data_d  = rd_data_q;
        error_d    = error_q;
        timer_load = 1'b0;
        timer_val  = WePulseM1;
        unique case (state_q)
            StIdle: begin
                if (bus.StartWrite) begin
                    state_d    = StCmdSetup;
                    rd_op_d    = 1'b0;
                    wr_data_d  = bus.WrData;
                    k_d        = 2'd0;
                    poll_cnt_d = 11'd0;
                    error_d    = 1'b0;
                end else if (bus.StartRead) begin
                    state_d = StCmdSetup;
                    rd_op_d = 1'b1;
                    error_d = 1'b0;
                end
            end
            StCmdSetup: begin
                timer_load = 1'b1;
                if (rd_op_q) begin
                    state_d   = StRdOe;
                    timer_val = RdWaitM1;
                end else begin
                    state_d = StCmdWe;
                end
            end
            StCmdWe: if (timer_zero) state_d = StCmdRec;
            StCmdRec: begin
                if (k_q == 2'd3) begin
                    state_d    = StPollOe;
                    timer_load = 1'b1;
                    timer_val  = RdWaitM1;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = StCmdSetup;
                end
            end
            StPollOe: if (timer_zero) state_d = StPollChk;
            StPollChk: begin
                if (bus.FlashDQ_in[7] == wr_data_q[7]) begin
                    state_d = StFinish;
                end else begin
                    poll_cnt_d = (poll_cnt_q == 11'h7FF) ? poll_cnt_q : poll_cnt_q + 11'd1;
                    if (poll_cnt_d >= PollMax) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d    = StPollOe;
                        timer_load = 1'b1;
                        timer_val  = RdWaitM1;
                    end
                end
            end
            StRdOe: begin
                if (timer_zero) begin
                    rd_data_d = bus.FlashDQ_in;
                    state_d   = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd             = cmd_step(k_q, wr_data_q);
        sel             = SEL_XXXX;
        bus.CE_n        = 1'b1;
        bus.WE_n        = 1'b1;
        bus.OE_n        = 1'b1;
        bus.FlashDQ_oe  = 1'b0;
        bus.FlashDQ_out = 8'h00;
        bus.Busy        = 1'b1;
        bus.Done        = 1'b0;
        bus.IncrAddr    = 1'b0;
        unique case (state_q)
            StIdle: bus.Busy = 1'b0;
            StCmdSetup, StCmdRec, StCmdWe: begin
                bus.CE_n = 1'b0;
                if (rd_op_q) begin
                    sel = SEL_ADDR;
                end else begin
                    sel             = cmd.sel;
                    bus.FlashDQ_oe  = 1'b1;
                    bus.FlashDQ_out = cmd.data;
                    bus.WE_n        = (state_q != StCmdWe);
                end
            end
            StPollOe: begin
                sel      = SEL_HOLD;
                bus.CE_n = 1'b0;
                bus.OE_n = 1'b0;
            end
            StPollChk: begin
                sel      = SEL_HOLD;
                bus.CE_n = 1'b0;
            end
            StRdOe: begin
                sel      = SEL_ADDR;
                bus.CE_n = 1'b0;
                bus.OE_n = 1'b0;
            end
            StFinish: begin
                bus.Done     = 1'b1;
                bus.IncrAddr = 1'b1;
            end
            default: bus.Busy = 1'b0;
        endcase
    end

    assign bus.SelAddr = sel[0];
    assign bus.Sel5555 = sel[1];
    assign bus.SelAAAA = sel[2];
    assign bus.SelHOLD = sel[3];
    assign bus.SelXXXX = sel[4];
    assign bus.RdData  = rd_data_q;
    assign bus.Error   = error_q;
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: per-cycle expected bus timeline built from the
// operation rules, compared every cycle, plus directed latency/value pins.
module tb_flash_cmd_sequencer;
    localparam int unsigned WE_PULSE = 2;
    localparam int unsigned RD_WAIT  = 2;
    localparam int unsigned POLL_MAX = 4;

    localparam logic [4:0] S_ADDR = 5'b00001;
    localparam logic [4:0] S_5555 = 5'b00010;
    localparam logic [4:0] S_AAAA = 5'b00100;
    localparam logic [4:0] S_HOLD = 5'b01000;
    localparam logic [4:0] S_XXXX = 5'b10000;

    typedef struct {
        logic       ce_n, we_n, oe_n, dq_oe;
        logic [7:0] dq_out;
        logic       dq_care;
        logic [4:0] sel;
        logic       incr, busy, done, err;
        logic [7:0] rd;
        logic [7:0] dq_in;
    } exp_t;

    logic SCL;
    logic Reset;
    flash_cmd_sequencer_if bus ();

    flash_cmd_sequencer #(
        .WE_PULSE (WE_PULSE),
        .RD_WAIT  (RD_WAIT),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .SCL   (SCL),
        .Reset (Reset),
        .bus   (bus)
    );

    initial SCL = 1'b0;
    always #5 SCL = ~SCL;

    int         n_checks;
    int         n_errors;
    bit         chk_en;
    exp_t       q[$];
    logic       mdl_err;
    logic [7:0] mdl_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic ce_n, input logic we_n, input logic oe_n,
                                input logic dq_oe, input logic [7:0] dq, input logic care,
                                input logic [4:0] sel);
        exp_t e;
        e.ce_n = ce_n; e.we_n = we_n; e.oe_n = oe_n; e.dq_oe = dq_oe;
        e.dq_out = dq; e.dq_care = care; e.sel = sel;
        e.incr = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
        e.rd = mdl_rd; e.dq_in = 8'($urandom);
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, S_XXXX);
        e.busy = 1'b0;
        e.err  = mdl_err;
        return e;
    endfunction

    function automatic exp_t fin();
        exp_t e;
        e = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, S_XXXX);
        e.incr = 1'b1;
        e.done = 1'b1;
        return e;
    endfunction

    // Program: 4 command bus cycles, then polls; poll number 'fails' is the first match.
    task automatic build_write(input logic [7:0] w, input int fails);
        logic [7:0] d[4];
        logic [4:0] s[4];
        logic [7:0] pv;
        exp_t       e;
        d = '{8'hAA, 8'h55, 8'hA0, w};
        s = '{S_5555, S_AAAA, S_5555, S_ADDR};
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, d[k], 1'b1, s[k]));
            repeat (WE_PULSE) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, d[k], 1'b1, s[k]));
            q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, d[k], 1'b1, s[k]));
        end
        for (int p = 0; p < int'(POLL_MAX); p++) begin
            pv    = 8'($urandom);
            pv[7] = (p == fails) ? w[7] : ~w[7];
            repeat (RD_WAIT) begin
                e = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, S_HOLD);
                e.dq_in = pv;
                q.push_back(e);
            end
            e = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, S_HOLD);
            e.dq_in = pv;
            q.push_back(e);
            if (p == fails) begin
                q.push_back(fin());
                return;
            end
        end
        mdl_err = 1'b1;
    endtask

    task automatic build_read(input logic [7:0] rv);
        exp_t e;
        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, S_ADDR));
        for (int r = 0; r < int'(RD_WAIT); r++) begin
            e = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, S_ADDR);
            if (r == int'(RD_WAIT) - 1) e.dq_in = rv;
            q.push_back(e);
        end
        mdl_rd = rv;
        q.push_back(fin());
    endtask

    // Compare process: also plays the flash by presenting each cycle's planned DQ input.
    always @(negedge SCL) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() != 0) e = q.pop_front();
            else               e = idle_exp();
            bus.FlashDQ_in = e.dq_in;
            chk("strobes", {bus.CE_n, bus.WE_n, bus.OE_n, bus.FlashDQ_oe},
                {e.ce_n, e.we_n, e.oe_n, e.dq_oe});
            chk("sel", {bus.SelXXXX, bus.SelHOLD, bus.SelAAAA, bus.Sel5555, bus.SelAddr}, e.sel);
            chk("sel_onehot", 32'($onehot({bus.SelXXXX, bus.SelHOLD, bus.SelAAAA,
                                           bus.Sel5555, bus.SelAddr})), 32'd1);
            chk("status", {bus.IncrAddr, bus.Busy, bus.Done, bus.Error},
                {e.incr, e.busy, e.done, e.err});
            chk("rd_data", bus.RdData, e.rd);
            if (e.dq_care) chk("dq_out", bus.FlashDQ_out, e.dq_out);
        end else begin
            bus.FlashDQ_in = 8'h00;
        end
    end

    // Called one time unit after a posedge with the DUT idle; returns at the same
    // phase in the first idle cycle after the operation. poke: 0 none, -1 random.
    task automatic run_op(input bit is_wr, input bit both, input logic [7:0] w,
                          input int fails, input logic [7:0] rv, input int poke,
                          output int lat, output int we_lo, output int oe_hi,
                          output int dones, output int incrs);
        int len;
        int pk;
        lat = -1; we_lo = 0; oe_hi = 0; dones = 0; incrs = 0;
        q.push_back(idle_exp());
        mdl_err = 1'b0;
        if (is_wr || both) build_write(w, fails);
        else               build_read(rv);
        len = q.size() - 1;
        pk  = (poke < 0) ? int'($urandom_range(1, len - 1)) : poke;
        bus.WrData     = w;
        bus.StartWrite = is_wr || both;
        bus.StartRead  = !is_wr || both;
        for (int i = 0; i <= len; i++) begin
            @(negedge SCL);
            if (i > 0) begin
                if (!bus.WE_n) we_lo++;
                if (bus.FlashDQ_oe) oe_hi++;
                if (bus.IncrAddr) incrs++;
                if (bus.Done) begin
                    dones++;
                    if (lat < 0) lat = i;
                end
            end
            @(posedge SCL);
            #1;
            bus.StartWrite = 1'b0;
            bus.StartRead  = 1'b0;
            bus.WrData     = 8'($urandom);
            if (pk > 0 && i + 1 == pk) begin
                if ($urandom_range(0, 1) == 1) bus.StartRead = 1'b1;
                else                           bus.StartWrite = 1'b1;
            end
        end
    endtask

    initial begin
        int lat, we_lo, oe_hi, dones, incrs, inc_sum, kind, fails, gap;
        n_checks = 0; n_errors = 0; chk_en = 1'b0;
        mdl_err = 1'b0; mdl_rd = 8'h00;
        Reset = 1'b1;
        bus.StartWrite = 1'b0; bus.StartRead = 1'b0; bus.WrData = 8'h00;
        repeat (2) @(posedge SCL);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge SCL);
        #1 Reset = 1'b0;
        @(negedge SCL);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_ce_n", bus.CE_n, 1);
        chk("rst_selxxxx", bus.SelXXXX, 1);
        @(posedge SCL);
        #1;

        // Program 5A: first poll sees DQ7=1 (busy), second sees DQ7=0 (done).
        run_op(1'b1, 1'b0, 8'h5A, 1, 8'h00, 0, lat, we_lo, oe_hi, dones, incrs);
        chk("wr5a_latency", lat, 23);
        chk("wr5a_we_low_cycles", we_lo, 8);
        chk("wr5a_done_count", dones, 1);
        chk("wr5a_incr_count", incrs, 1);

        run_op(1'b0, 1'b0, 8'h00, 0, 8'hC3, 0, lat, we_lo, oe_hi, dones, incrs);
        chk("rdc3_latency", lat, 4);
        chk("rdc3_we_low_cycles", we_lo, 0);
        chk("rdc3_dq_oe_cycles", oe_hi, 0);
        chk("rdc3_rddata", bus.RdData, 8'hC3);

        // Both starts together run the write; a StartRead mid-operation is ignored.
        run_op(1'b1, 1'b1, 8'h81, 0, 8'h00, 5, lat, we_lo, oe_hi, dones, incrs);
        chk("both_we_low_cycles", we_lo, 8);
        chk("both_done_count", dones, 1);

        // DQ7 never matches: Error after the 4th check, no completion.
        run_op(1'b1, 1'b0, 8'h00, 99, 8'h00, 0, lat, we_lo, oe_hi, dones, incrs);
        chk("to_done_count", dones, 0);
        chk("to_incr_count", incrs, 0);
        chk("to_error", bus.Error, 1);
        run_op(1'b0, 1'b0, 8'h00, 0, 8'h3E, 0, lat, we_lo, oe_hi, dones, incrs);
        chk("to_error_cleared", bus.Error, 0);

        run_op(1'b0, 1'b0, 8'h00, 0, 8'h11, 0, lat, we_lo, oe_hi, dones, incrs);
        inc_sum = incrs;
        run_op(1'b0, 1'b0, 8'h00, 0, 8'hEE, 0, lat, we_lo, oe_hi, dones, incrs);
        inc_sum += incrs;
        chk("b2b_incr_count", inc_sum, 2);

        // Reset during the WE_n pulse of the third command cycle.
        q.push_back(idle_exp());
        mdl_err = 1'b0;
        build_write(8'h3C, 0);
        bus.WrData = 8'h3C;
        bus.StartWrite = 1'b1;
        @(posedge SCL);
        #1 bus.StartWrite = 1'b0;
        repeat (9) @(posedge SCL);
        #1 Reset = 1'b1;
        @(negedge SCL);
        chk("pre_rst_we_n", bus.WE_n, 0);
        chk("pre_rst_sel5555", bus.Sel5555, 1);
        #1;
        q.delete();
        mdl_err = 1'b0;
        mdl_rd = 8'h00;
        @(posedge SCL);
        #1 Reset = 1'b0;
        @(negedge SCL);
        chk("mid_rst_we_n", bus.WE_n, 1);
        chk("mid_rst_ce_n", bus.CE_n, 1);
        chk("mid_rst_selxxxx", bus.SelXXXX, 1);
        chk("mid_rst_busy", bus.Busy, 0);
        chk("mid_rst_done", bus.Done, 0);
        @(posedge SCL);
        #1;

        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge SCL);
                #1;
            end
            kind  = $urandom_range(0, 2);
            fails = $urandom_range(0, 5);
            run_op(kind != 1, kind == 2, 8'($urandom), fails, 8'($urandom),
                   ($urandom_range(0, 1) == 1) ? -1 : 0, lat, we_lo, oe_hi, dones, incrs);
        end
        repeat (3) @(posedge SCL);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
